// File: rtl/bus_arbiter_4.sv
// Round-robin 4-way arbiter and sequencer for the shared 16-bit bus.
// Optional burst timeout: define ARB_TIMEOUT_EN.

module mux_16_4 (
  input  logic [15:0] d0,
  input  logic [15:0] d1,
  input  logic [15:0] d2,
  input  logic [15:0] d3,
  input  logic        s1,
  input  logic        s0,
  output logic [15:0] y
);

  // Select one of four words by {s1,s0}
  always_comb begin
    unique case ({s1, s0})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

module bus_arbiter_4 (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [3:0]  LAST,
  input  logic [15:0] D0,
  input  logic [15:0] D1,
  input  logic [15:0] D2,
  input  logic [15:0] D3,
  input  logic        READY,
  output logic [3:0]  GNT,
  output logic [3:0]  ACK,
  output logic        S0,
  output logic        S1,
  output logic [15:0] Y,
  output logic        VALID
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic [1:0]  ptr;
  logic [1:0]  g;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic        free;
  logic        take;
  logic        tmo;
  logic        fin;
  logic [15:0] mux_y;

  assign g    = {S1, S0};
  assign free = !VALID || READY;

  // ACK is masked while reset is asserted so nothing leaks out mid-reset
  assign take = RST_N && (state == BUSY)
             && GNT[g] && REQ[g] && free;
  assign ACK  = take ? (4'b0001 << g) : 4'b0000;

  mux_16_4 u_mux (
    .d0 (D0),
    .d1 (D1),
    .d2 (D2),
    .d3 (D3),
    .s1 (S1),
    .s0 (S0),
    .y  (mux_y)
  );

  // First requester at or after the priority pointer
  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && REQ[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [1:0] idle_cnt;

  assign tmo = (state == BUSY) && !REQ[g]
            && (idle_cnt == 2'd3);

  // Count consecutive BUSY cycles with the granted request low
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idle_cnt <= 2'd0;
    end else if (state == IDLE || take || REQ[g]) begin
      idle_cnt <= 2'd0;
    end else begin
      idle_cnt <= idle_cnt + 2'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign fin = (take && LAST[g]) || tmo;

  // Grant FSM: selects only move when a new burst is granted
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      GNT   <= 4'b0000;
      S1    <= 1'b0;
      S0    <= 1'b0;
      ptr   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|REQ) begin
            state    <= BUSY;
            GNT      <= 4'b0001 << pick;
            {S1, S0} <= pick;
          end
        end
        BUSY: begin
          if (fin) begin
            state <= IDLE;
            GNT   <= 4'b0000;
            ptr   <= g + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on ACK, drain on READY, independent of FSM
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Y     <= 16'h0000;
      VALID <= 1'b0;
    end else if (take) begin
      Y     <= mux_y;
      VALID <= 1'b1;
    end else if (VALID && READY) begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Scoreboard bench for bus_arbiter_4.
// Directed vectors; accepted beats checked by a monitor.

module tb_bus_arbiter_4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [3:0]  LAST;
  logic [15:0] D0, D1, D2, D3;
  logic        READY;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic        S0, S1;
  logic [15:0] Y;
  logic        VALID;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] sbq[$];

  bus_arbiter_4 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .LAST  (LAST),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .READY (READY),
    .GNT   (GNT),
    .ACK   (ACK),
    .S0    (S0),
    .S1    (S1),
    .Y     (Y),
    .VALID (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the queue head
  always @(negedge CLK) begin
    if (VALID === 1'b1 && READY === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL y_extra: got %0h want none", Y);
      end else begin
        chk("y_beat", {16'h0, Y}, {16'h0, sbq.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input logic [3:0]  req,
                     input logic [3:0]  last,
                     input logic        rdy,
                     input logic [3:0]  e_gnt,
                     input logic [3:0]  e_ack,
                     input logic [15:0] e_y,
                     input string       nm);
    REQ   = req;
    LAST  = last;
    READY = rdy;
    #1;
    chk({nm, " gnt"}, {28'h0, GNT}, {28'h0, e_gnt});
    chk({nm, " ack"}, {28'h0, ACK}, {28'h0, e_ack});
    if (e_ack != 4'b0000) sbq.push_back(e_y);
    step();
  endtask

  initial begin
    RST_N = 1'b0;
    REQ   = 4'b1111;
    LAST  = 4'b0000;
    READY = 1'b1;
    D0 = 16'h0; D1 = 16'h0;
    D2 = 16'hA5A5; D3 = 16'h0;
    step();
    step();
    chk("rst gnt", {28'h0, GNT}, 32'h0);
    chk("rst sel", {30'h0, S1, S0}, 32'h0);
    chk("rst y", {16'h0, Y}, 32'h0);
    chk("rst valid", {31'h0, VALID}, 32'h0);
    chk("rst ack", {28'h0, ACK}, 32'h0);
    REQ   = 4'b0000;
    RST_N = 1'b1;
    step();

    // single requester, 3-beat burst
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "t1 c0");
    chk("t1 sel", {30'h0, S1, S0}, 32'h2);
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 16'hA5A5, "t1 b1");
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 16'hA5A5, "t1 b2");
    cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 16'hA5A5, "t1 b3");
    chk("t1 valid", {31'h0, VALID}, 32'h1);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "t1 idle");
    chk("t1 drain", {31'h0, VALID}, 32'h0);

    // wrap: pointer at 3 after burst from 2
    D3 = 16'h3333;
    D0 = 16'h0CC0;
    cyc(4'b1001, 4'b1111, 1'b1, 4'b0000, 4'b0000, 16'h0, "wr c0");
    chk("wr sel3", {30'h0, S1, S0}, 32'h3);
    cyc(4'b1001, 4'b1111, 1'b1, 4'b1000, 4'b1000, 16'h3333, "wr g3");
    chk("wr selhold", {30'h0, S1, S0}, 32'h3);
    cyc(4'b1001, 4'b1111, 1'b1, 4'b0000, 4'b0000, 16'h0, "wr bub");
    chk("wr sel0", {30'h0, S1, S0}, 32'h0);
    cyc(4'b1001, 4'b1111, 1'b1, 4'b0001, 4'b0001, 16'h0CC0, "wr g0");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "wr end");

    // backpressure on requester 1
    D1 = 16'h1111;
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "bp c0");
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 16'h1111, "bp b1");
    D1 = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("bp y", {16'h0, Y}, 32'h1111);
      chk("bp valid", {31'h0, VALID}, 32'h1);
      cyc(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 16'h0, "bp hold");
    end
    cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 16'hBEEF, "bp b2");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "bp end");

    // reset during second beat of a long burst
    D2 = 16'h2222;
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "mr c0");
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 16'h2222, "mr b1");
    RST_N = 1'b0;
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 16'h0, "mr rst");
    RST_N = 1'b1;
    chk("mr valid", {31'h0, VALID}, 32'h0);
    chk("mr y", {16'h0, Y}, 32'h0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "mr idle");

    // round robin from pointer 0, single-beat bursts
    D0 = 16'h1000; D1 = 16'h1001;
    D2 = 16'h1002; D3 = 16'h1003;
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 16'h0, "rr bub");
      cyc(4'b1111, 4'b1111, 1'b1, 4'b0001 << (k % 4),
          4'b0001 << (k % 4), 16'h1000 + 16'(k % 4), "rr g");
    end
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "rr end");

    // granted 0 drops REQ while 1 waits
    D0 = 16'h7777;
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "to c0");
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 16'h7777, "to b1");
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0000, 16'h0, "to low");
    end
`ifdef ARB_TIMEOUT_EN
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'h0, "to idle");
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 16'h1001, "to g1");
`else
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0000, 16'h0, "to hold");
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0000, 16'h0, "to hold");
`endif
    REQ = 4'b0000;
    step();
    step();
    chk("sb empty", sbq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
